timer: RTL

TIMER -- requirements
Module: timer

---
 rtl/timer.sv | 72 +++++++
 1 files changed

// File: rtl/timer.sv
// timer: CPU-programmable 32-bit down-counter with one-shot/auto-reload modes and a maskable IRQ
module timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  state_t      state, state_nx;
  logic [3:0]  ctrl;
  logic [31:0] preset, count, count_nx;
  logic        irq_flag, hw_set, hw_clr_flag, hw_clr_en;
  logic        wr_ctrl, wr_preset;
  assign wr_ctrl   = We && Addr == 2'd0;
  assign wr_preset = We && Addr == 2'd1;
  always_comb begin
    state_nx    = state;
    count_nx    = count;
    hw_set      = 1'b0;
    hw_clr_flag = 1'b0;
    hw_clr_en   = 1'b0;
    case (state)
      IDLE: state_nx = ctrl[0] ? LOAD : IDLE;
      LOAD: begin
        count_nx = preset;
        state_nx = CNT;
      end
      CNT:
        if (!ctrl[0]) state_nx = IDLE;
        else if (count > 32'd1) count_nx = count - 32'd1;
        else begin
          count_nx = '0;
          hw_set   = 1'b1;
          state_nx = INT;
        end
      INT:
        if (ctrl[2:1] == 2'd1) begin
          hw_clr_flag = 1'b1;
          state_nx    = LOAD;
        end else begin
          hw_clr_en = 1'b1;
          state_nx  = IDLE;
        end
      default: state_nx = IDLE;
    endcase
  end
  // a hardware expiry wins over a same-cycle CPU clear; a CPU CTRL write wins over the hardware Enable clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      ctrl     <= wr_ctrl ? Din[3:0] : {ctrl[3:1], ctrl[0] & ~hw_clr_en};
      preset   <= wr_preset ? Din : preset;
      irq_flag <= hw_set | (irq_flag & ~hw_clr_flag & ~wr_ctrl & ~wr_preset);
    end
  end
  always_comb
    Dout = !reset          ? '0 :
           Addr == 2'd0    ? {28'b0, ctrl} :
           Addr == 2'd1    ? preset :
           Addr == 2'd2    ? count : '0;
  assign IRQ = irq_flag & ctrl[3];
endmodule
